// File: rtl/digital_clock_ctrl_if.sv
// Control, load, alarm and display signals of the digital clock controller.
// The master modport drives requests; the slave modport is the controller side.
`timescale 1ns/1ps
interface digital_clock_ctrl_if;
  logic        run;
  logic        mode_12h;
  logic        load_valid;
  logic [16:0] load_time;
  logic        load_ok;
  logic        load_err;
  logic        alarm_en;
  logic [16:0] alarm_time;
  logic        alarm_hit;
  logic        sec_pulse;
  logic        day_wrap;
  logic [16:0] time_out;
  logic        pm;

  modport master (
    output run, mode_12h, load_valid, load_time, alarm_en, alarm_time,
    input  load_ok, load_err, alarm_hit, sec_pulse, day_wrap, time_out, pm
  );

  modport slave (
    input  run, mode_12h, load_valid, load_time, alarm_en, alarm_time,
    output load_ok, load_err, alarm_hit, sec_pulse, day_wrap, time_out, pm
  );
endinterface

// File: rtl/digital_clock_ctrl.sv
// hh:mm:ss time-of-day counter with internal seconds prescaler, validated load,
// run/pause, 12/24-hour display, alarm compare and day-rollover pulse.
`timescale 1ns/1ps
module digital_clock_ctrl #(
  parameter int CLK_HZ = 50000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  digital_clock_ctrl_if.slave   bus
);

  localparam int PRE_W = $clog2(CLK_HZ);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_HZ - 1);

  logic [PRE_W-1:0] pre_cnt;
  logic [4:0]       hour;
  logic [5:0]       min;
  logic [5:0]       sec;

  logic [4:0]       hour_adv;
  logic [5:0]       min_adv;
  logic [5:0]       sec_adv;

  logic [4:0]       load_hour;
  logic [5:0]       load_min;
  logic [5:0]       load_sec;

  logic             tick;
  logic             load_in_range;
  logic             load_accept;
  logic             advance;
  logic             at_day_end;
  logic             sec_pulse_q;
  logic             day_wrap_q;
  logic             alarm_hit_q;
  logic             load_ok_q;
  logic             load_err_q;
  logic [4:0]       hour_disp;

  assign load_hour = bus.load_time[16:12];
  assign load_min  = bus.load_time[11:6];
  assign load_sec  = bus.load_time[5:0];

  assign tick          = bus.run && (pre_cnt == PRE_MAX);
  assign load_in_range = (load_hour <= 5'd23) && (load_min <= 6'd59) && (load_sec <= 6'd59);
  assign load_accept   = bus.load_valid && load_in_range;
  // An accepted load overrides a coincident tick; a rejected load lets it through.
  assign advance       = tick && !load_accept;
  assign at_day_end    = (hour == 5'd23) && (min == 6'd59) && (sec == 6'd59);

  always_comb begin
    sec_adv  = sec + 6'd1;
    min_adv  = min;
    hour_adv = hour;
    if (sec == 6'd59) begin
      sec_adv = 6'd0;
      min_adv = min + 6'd1;
      if (min == 6'd59) begin
        min_adv  = 6'd0;
        hour_adv = (hour == 5'd23) ? 5'd0 : hour + 5'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt     <= '0;
      hour        <= '0;
      min         <= '0;
      sec         <= '0;
      sec_pulse_q <= 1'b0;
      day_wrap_q  <= 1'b0;
      alarm_hit_q <= 1'b0;
      load_ok_q   <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      if (load_accept) begin
        pre_cnt <= '0;
        hour    <= load_hour;
        min     <= load_min;
        sec     <= load_sec;
      end else begin
        if (bus.run) begin
          pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
        end
        if (advance) begin
          hour <= hour_adv;
          min  <= min_adv;
          sec  <= sec_adv;
        end
      end
      sec_pulse_q <= advance;
      day_wrap_q  <= advance && at_day_end;
      alarm_hit_q <= advance && bus.alarm_en && ({hour_adv, min_adv, sec_adv} == bus.alarm_time);
      load_ok_q   <= load_accept;
      load_err_q  <= bus.load_valid && !load_in_range;
    end
  end

  // Display conversion only; stored time stays in 24-hour form.
  always_comb begin
    hour_disp = hour;
    if (bus.mode_12h) begin
      if (hour == 5'd0) begin
        hour_disp = 5'd12;
      end else if (hour > 5'd12) begin
        hour_disp = hour - 5'd12;
      end
    end
  end

  assign bus.time_out  = {hour_disp, min, sec};
  assign bus.pm        = (hour >= 5'd12);
  assign bus.sec_pulse = sec_pulse_q;
  assign bus.day_wrap  = day_wrap_q;
  assign bus.alarm_hit = alarm_hit_q;
  assign bus.load_ok   = load_ok_q;
  assign bus.load_err  = load_err_q;

endmodule
